// File: rtl/alu_shift_seq.sv
// rtl/alu_shift_seq.sv - variable-amount shift sequencer built on a one-bit-per-op ALU
module alu_shift_seq #(
    parameter int         WIDTH    = 32,
    parameter int         SHAMT_W  = 5,
    parameter logic [3:0] CTRL_SLL = 4'h5,
    parameter logic [3:0] CTRL_SRL = 4'h6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    input  logic [WIDTH-1:0]   pipe_in1,
    input  logic [WIDTH-1:0]   pipe_in2,
    input  logic [3:0]         pipe_ctrl,
    input  logic [WIDTH-1:0]   alu_out,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [3:0]         alu_ctrl,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] count;
    logic               dir_q;
    logic               accept;

    assign accept = start && !flush;

    always_comb begin
        state_nx = state;
        alu_in1  = pipe_in1;
        alu_in2  = pipe_in2;
        alu_ctrl = pipe_ctrl;
        stall    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                alu_in1  = acc;
                alu_in2  = '0;
                alu_ctrl = dir_q ? CTRL_SRL : CTRL_SLL;
                stall    = 1'b1;
                busy     = 1'b1;
                if (flush)
                    state_nx = IDLE;
                else if (count == SHAMT_W'(1))
                    state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = !flush;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // acc already holds the final value in DONE; result_q only commits it when
    // the DONE cycle is not flushed, so an aborted op leaves the old result.
    assign result = (state == DONE) ? acc : result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= operand;
                        count <= shamt;
                        dir_q <= dir;
                    end
                end
                SHIFT: begin
                    if (!flush) begin
                        acc   <= alu_out;
                        count <= count - SHAMT_W'(1);
                    end
                end
                DONE: begin
                    if (!flush)
                        result_q <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb/tb_alu_shift_seq.sv - self-checking bench for alu_shift_seq
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        flush;
    logic [31:0] pipe_in1;
    logic [31:0] pipe_in2;
    logic [3:0]  pipe_ctrl;
    logic [31:0] alu_out;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    alu_shift_seq dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .operand(operand),
        .shamt(shamt), .flush(flush), .pipe_in1(pipe_in1), .pipe_in2(pipe_in2),
        .pipe_ctrl(pipe_ctrl), .alu_out(alu_out), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_ctrl)
            4'h5:    alu_out = alu_in1 << 1;
            4'h6:    alu_out = alu_in1 >> 1;
            default: alu_out = alu_in1 + alu_in2;
        endcase
    end

    typedef struct {
        logic        d;
        logic [31:0] op;
        logic [4:0]  sa;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one shift and follow it to done, checking latency, op count and result.
    task automatic do_shift(input logic d, input logic [31:0] op, input logic [4:0] sa,
                            input logic [31:0] exp, input string name);
        int  cyc;
        int  shifts;
        int  stalls;
        bit  got;
        @(negedge clk);
        start = 1'b1; dir = d; operand = op; shamt = sa;
        #1 check({name, "_stall_start"}, 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; shifts = 0; stalls = 0; got = 0;
        while (!got && cyc <= 40) begin
            #1;
            if (done) begin
                got = 1;
                check({name, "_latency"}, 32'(cyc), 32'(sa) + 32'd1);
                check({name, "_result"}, result, exp);
                check({name, "_stall_done"}, 32'(stall), 32'd0);
            end else begin
                if (alu_ctrl == (d ? 4'h6 : 4'h5)) shifts++;
                if (stall) stalls++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_shift_ops"}, 32'(shifts), 32'(sa));
        check({name, "_stall_cycles"}, 32'(stalls), 32'(sa));
        @(negedge clk);
        #1 check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({name, "_result_held"}, result, exp);
    endtask

    initial begin
        logic [31:0] old;
        logic [31:0] rop;
        logic [4:0]  rsa;
        logic        rd;
        int          seen;

        vecs[0] = '{1'b0, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{1'b1, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[4] = '{1'b0, 32'hF000_000F, 5'd1,  32'hE000_001E};
        vecs[5] = '{1'b1, 32'h1234_5678, 5'd8,  32'h0012_3456};

        rst = 1'b1; start = 1'b0; dir = 1'b0; operand = '0; shamt = '0; flush = 1'b0;
        pipe_in1 = '0; pipe_in2 = '0; pipe_ctrl = 4'h0;
        #12;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        pipe_in1 = 32'd3; pipe_in2 = 32'd4; pipe_ctrl = 4'h0;
        #1;
        check("pass_in1",   alu_in1, 32'd3);
        check("pass_in2",   alu_in2, 32'd4);
        check("pass_ctrl",  {28'd0, alu_ctrl}, 32'd0);
        check("pass_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 6; i++)
            do_shift(vecs[i].d, vecs[i].op, vecs[i].sa, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rd  = 1'($urandom);
            rop = $urandom;
            rsa = 5'($urandom_range(0, 31));
            do_shift(rd, rop, rsa, rd ? (rop >> rsa) : (rop << rsa), $sformatf("rnd%0d", i));
        end

        // start during SHIFT must be ignored
        @(negedge clk);
        start = 1'b1; dir = 1'b0; operand = 32'h0000_0003; shamt = 5'd3;
        @(negedge clk);
        operand = 32'hFFFF_FFFF; shamt = 5'd10; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 2; c <= 12; c++) begin
            #1;
            if (done) begin
                if (seen == 0) begin
                    check("restart_latency", 32'(c), 32'd4);
                    check("restart_result",  result, 32'h0000_0018);
                end
                seen++;
            end
            @(negedge clk);
        end
        check("restart_single_done", 32'(seen), 32'd1);

        // flush at cycle 2 of an 8-bit shift
        old = result;
        start = 1'b1; dir = 1'b0; operand = 32'h0000_00FF; shamt = 5'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy",   {31'd0, busy}, 32'd0);
        check("flush_stall",  {31'd0, stall}, 32'd0);
        check("flush_result", result, old);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1 if (done) seen++;
        end
        check("flush_no_done", 32'(seen), 32'd0);

        // flush in DONE suppresses done and the result update
        @(negedge clk);
        start = 1'b1; dir = 1'b0; operand = 32'hCAFE_0001; shamt = 5'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1 check("flush_done_pulse", {31'd0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_done_result", result, old);

        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; operand = 32'h1; shamt = 5'd2;
        #1 check("flush_start_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 check("flush_start_busy", {31'd0, busy}, 32'd0);

        // async reset mid-shift
        @(negedge clk);
        start = 1'b1; dir = 1'b1; operand = 32'h8000_0000; shamt = 5'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pipe_in1 = 32'd7; pipe_in2 = 32'd9; pipe_ctrl = 4'h2;
        #2 rst = 1'b1;
        #1;
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall",  {31'd0, stall}, 32'd0);
        check("rst_ctrl",   {28'd0, alu_ctrl}, 32'd2);
        check("rst_in1",    alu_in1, 32'd7);
        @(negedge clk);
        rst = 1'b0; pipe_ctrl = 4'h0;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            #1 if (done) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);

        do_shift(1'b0, 32'h0000_0001, 5'd5, 32'h0000_0020, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
